// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares one synchronous data_mem between the pipeline load/store
//            stage (P0) and the debug/loader port (P1), with locked sequences.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_wstrb,
    input  logic              p0_lock,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_wstrb,
    input  logic              p1_lock,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,

    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] c_OWN_NONE = 2'b00;
    localparam logic [1:0] c_OWN_P0   = 2'b01;
    localparam logic [1:0] c_OWN_P1   = 2'b10;

    logic [1:0]        r_owner;
    logic              r_rd_pend;
    logic              r_rd_own1;

    logic              w_pick1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [3:0]        w_sel_wstrb;

    // w_pick1 only decides ties when nobody holds the lock.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            case (r_owner)
                c_OWN_P0: w_gnt0 = p0_valid;
                c_OWN_P1: w_gnt1 = p1_valid;
                default: begin
                    if (p0_valid && p1_valid) begin
                        w_gnt1 = w_pick1;
                        w_gnt0 = !w_pick1;
                    end else begin
                        w_gnt0 = p0_valid;
                        w_gnt1 = p1_valid;
                    end
                end
            endcase
        end
    end

    generate
        if (ARB_MODE == 0) begin : g_rr
            logic r_last_p0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_last_p0 <= 1'b0;
                end else if (w_gnt0) begin
                    r_last_p0 <= 1'b1;
                end else if (w_gnt1) begin
                    r_last_p0 <= 1'b0;
                end
            end

            assign w_pick1 = r_last_p0;
        end else begin : g_fixed
            localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);
            localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

            logic [c_WAIT_W-1:0] r_wait_cnt;

            // The counter is frozen while either side owns a locked sequence.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wait_cnt <= '0;
                end else if (w_gnt1) begin
                    r_wait_cnt <= '0;
                end else if (r_owner == c_OWN_NONE) begin
                    if (!p1_valid) begin
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != c_WAIT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
            end

            assign w_pick1 = (r_wait_cnt == c_WAIT_MAX);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= c_OWN_NONE;
            r_rd_pend <= 1'b0;
            r_rd_own1 <= 1'b0;
        end else begin
            if (w_gnt0) begin
                r_owner <= p0_lock ? c_OWN_P0 : c_OWN_NONE;
            end else if (w_gnt1) begin
                r_owner <= p1_lock ? c_OWN_P1 : c_OWN_NONE;
            end
            r_rd_pend <= (w_gnt0 && !p0_we) || (w_gnt1 && !p1_we);
            r_rd_own1 <= w_gnt1;
        end
    end

    assign p0_ready    = w_gnt0;
    assign p1_ready    = w_gnt1;
    assign w_any       = w_gnt0 | w_gnt1;

    assign w_sel_we    = w_gnt1 ? p1_we    : p0_we;
    assign w_sel_addr  = w_gnt1 ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_gnt1 ? p1_wdata : p0_wdata;
    assign w_sel_wstrb = w_gnt1 ? p1_wstrb : p0_wstrb;

    assign mem_re    = w_any & ~w_sel_we;
    assign mem_we    = w_any & w_sel_we;
    assign mem_raddr = mem_re ? w_sel_addr  : '0;
    assign mem_waddr = mem_we ? w_sel_addr  : '0;
    assign mem_wdata = mem_we ? w_sel_wdata : '0;
    assign mem_wstrb = mem_we ? w_sel_wstrb : 4'b0000;

    assign p0_rvalid = r_rd_pend & ~r_rd_own1;
    assign p1_rvalid = r_rd_pend & r_rd_own1;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Round-robin and fixed-priority arbiters driven by one stimulus
//            stream and checked against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_FX_WAIT = 3;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    logic        p0_valid, p0_we, p0_lock, p1_valid, p1_we, p1_lock;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_wstrb, p1_wstrb;

    logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_mre, a_mwe;
    logic [31:0] a_rd0, a_rd1, a_mra, a_mwa, a_mwd, a_mrd;
    logic [3:0]  a_mws;
    logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_mre, b_mwe;
    logic [31:0] b_rd0, b_rd1, b_mra, b_mwa, b_mwd, b_mrd;
    logic [3:0]  b_mws;

    logic [31:0] a_mem [64];
    logic [31:0] b_mem [64];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, one slot per instance (0 = round-robin, 1 = fixed).
    int          own   [2];
    int          last  [2];
    int          wt    [2];
    bit          pend  [2];
    int          pown  [2];
    logic [31:0] pdat  [2];
    logic [31:0] mm    [2][64];
    int          last_g[2];
    logic [31:0] seen  [2][12];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .ARB_MODE(0), .MAX_WAIT(8)) u_rr (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(a_rdy0), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb), .p0_lock(p0_lock),
        .p0_rvalid(a_rv0), .p0_rdata(a_rd0),
        .p1_valid(p1_valid), .p1_ready(a_rdy1), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb), .p1_lock(p1_lock),
        .p1_rvalid(a_rv1), .p1_rdata(a_rd1),
        .mem_re(a_mre), .mem_we(a_mwe), .mem_raddr(a_mra), .mem_waddr(a_mwa),
        .mem_wdata(a_mwd), .mem_wstrb(a_mws), .mem_rdata(a_mrd)
    );

    dmem_arbiter #(.ADDR_W(32), .ARB_MODE(1), .MAX_WAIT(c_FX_WAIT)) u_fx (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(b_rdy0), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb), .p0_lock(p0_lock),
        .p0_rvalid(b_rv0), .p0_rdata(b_rd0),
        .p1_valid(p1_valid), .p1_ready(b_rdy1), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb), .p1_lock(p1_lock),
        .p1_rvalid(b_rv1), .p1_rdata(b_rd1),
        .mem_re(b_mre), .mem_we(b_mwe), .mem_raddr(b_mra), .mem_waddr(b_mwa),
        .mem_wdata(b_mwd), .mem_wstrb(b_mws), .mem_rdata(b_mrd)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (st[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // Stand-ins for the two data_mem instances: synchronous read, byte writes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 64; k++) a_mem[k] <= '0;
        end else begin
            if (a_mwe) a_mem[a_mwa[7:2]] <= merge(a_mem[a_mwa[7:2]], a_mwd, a_mws);
            if (a_mre) a_mrd <= a_mem[a_mra[7:2]];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 64; k++) b_mem[k] <= '0;
        end else begin
            if (b_mwe) b_mem[b_mwa[7:2]] <= merge(b_mem[b_mwa[7:2]], b_mwd, b_mws);
            if (b_mre) b_mrd <= b_mem[b_mra[7:2]];
        end
    end

    function automatic logic [31:0] obs(int m, int s);
        case (s)
            0:  return 32'(m == 0 ? a_rdy0 : b_rdy0);
            1:  return 32'(m == 0 ? a_rdy1 : b_rdy1);
            2:  return 32'(m == 0 ? a_mre  : b_mre);
            3:  return 32'(m == 0 ? a_mwe  : b_mwe);
            4:  return m == 0 ? a_mra : b_mra;
            5:  return m == 0 ? a_mwa : b_mwa;
            6:  return m == 0 ? a_mwd : b_mwd;
            7:  return 32'(m == 0 ? a_mws : b_mws);
            8:  return 32'(m == 0 ? a_rv0 : b_rv0);
            9:  return 32'(m == 0 ? a_rv1 : b_rv1);
            10: return m == 0 ? a_rd0 : b_rd0;
            default: return m == 0 ? a_rd1 : b_rd1;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Who should win this cycle: -1 none, 0 P0, 1 P1.
    function automatic int pick(int m);
        if (own[m] == 0) return p0_valid ? 0 : -1;
        if (own[m] == 1) return p1_valid ? 1 : -1;
        if (p0_valid && p1_valid) begin
            if (m == 0) return (last[m] == 0) ? 1 : 0;
            return (wt[m] >= c_FX_WAIT) ? 1 : 0;
        end
        if (p0_valid) return 0;
        if (p1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            own[m]  = -1;
            last[m] = 1;
            wt[m]   = 0;
            pend[m] = 1'b0;
        end
    endtask

    task automatic model_update(int m, int g);
        logic        we, lk;
        logic [31:0] ad, wd;
        logic [3:0]  st;
        if (m == 1) begin
            if (g == 1) wt[1] = 0;
            else if (own[1] == -1) begin
                if (!p1_valid) wt[1] = 0;
                else if (wt[1] < c_FX_WAIT) wt[1]++;
            end
        end
        pend[m] = 1'b0;
        if (g >= 0) begin
            we = (g == 1) ? p1_we    : p0_we;
            lk = (g == 1) ? p1_lock  : p0_lock;
            ad = (g == 1) ? p1_addr  : p0_addr;
            wd = (g == 1) ? p1_wdata : p0_wdata;
            st = (g == 1) ? p1_wstrb : p0_wstrb;
            if (we) mm[m][ad[7:2]] = merge(mm[m][ad[7:2]], wd, st);
            else begin
                pend[m] = 1'b1;
                pown[m] = g;
                pdat[m] = mm[m][ad[7:2]];
            end
            own[m]  = lk ? g : -1;
            last[m] = g;
        end
    endtask

    // One clock: check both instances mid-cycle, then advance the model.
    task automatic step(string tag);
        int g [2];
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            bit          gv, gwe;
            logic [31:0] ga, gd;
            logic [3:0]  gs;
            for (int s = 0; s < 12; s++) seen[m][s] = obs(m, s);
            g[m] = pick(m);
            gv   = (g[m] >= 0);
            gwe  = (g[m] == 1) ? p1_we    : p0_we;
            ga   = (g[m] == 1) ? p1_addr  : p0_addr;
            gd   = (g[m] == 1) ? p1_wdata : p0_wdata;
            gs   = (g[m] == 1) ? p1_wstrb : p0_wstrb;
            chk($sformatf("%s i%0d p0_ready", tag, m), seen[m][0], 32'(g[m] == 0));
            chk($sformatf("%s i%0d p1_ready", tag, m), seen[m][1], 32'(g[m] == 1));
            chk($sformatf("%s i%0d mem_re", tag, m), seen[m][2], 32'(gv && !gwe));
            chk($sformatf("%s i%0d mem_we", tag, m), seen[m][3], 32'(gv && gwe));
            chk($sformatf("%s i%0d mem_wstrb", tag, m), seen[m][7], (gv && gwe) ? 32'(gs) : 32'h0);
            if (gv && !gwe) chk($sformatf("%s i%0d mem_raddr", tag, m), seen[m][4], ga);
            if (!gv) chk($sformatf("%s i%0d idle raddr", tag, m), seen[m][4], 32'h0);
            if (gv && gwe) begin
                chk($sformatf("%s i%0d mem_waddr", tag, m), seen[m][5], ga);
                chk($sformatf("%s i%0d mem_wdata", tag, m), seen[m][6], gd);
            end
            if (!gv) chk($sformatf("%s i%0d idle wdata", tag, m), seen[m][6], 32'h0);
            chk($sformatf("%s i%0d p0_rvalid", tag, m), seen[m][8], 32'(pend[m] && pown[m] == 0));
            chk($sformatf("%s i%0d p1_rvalid", tag, m), seen[m][9], 32'(pend[m] && pown[m] == 1));
            if (pend[m])
                chk($sformatf("%s i%0d rdata", tag, m), (pown[m] == 1) ? seen[m][11] : seen[m][10], pdat[m]);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_update(m, g[m]);
        last_g = g;
        #1;
    endtask

    task automatic drive(int p, bit v, bit we, logic [31:0] a, logic [31:0] d, logic [3:0] s, bit lk);
        if (p == 0) begin
            p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d; p0_wstrb = s; p0_lock = lk;
        end else begin
            p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d; p1_wstrb = s; p1_lock = lk;
        end
    endtask

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        drive(0, 1, 0, 32'h10, 32'h0, 4'h0, 0);
        drive(1, 1, 0, 32'h14, 32'h0, 4'h0, 0);
        model_reset();
        last_g = '{-1, -1};
        for (int m = 0; m < 2; m++)
            for (int w = 0; w < 64; w++) mm[m][w] = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state: requests pending but nothing may be granted or returned.
        for (int m = 0; m < 2; m++)
            for (int s = 0; s < 4; s++) chk($sformatf("reset i%0d sig%0d", m, s), obs(m, s), 32'h0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset i%0d p0_rvalid", m), obs(m, 8), 32'h0);
            chk($sformatf("reset i%0d p1_rvalid", m), obs(m, 9), 32'h0);
        end
        mem_init = 1'b0;
        rst      = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step("idle0");

        // Write then read back through P0; the read also carries a full strobe.
        drive(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        step("t2 write");
        drive(0, 1, 0, 32'h10, 32'h0, 4'hF, 0);
        step("t6 read");
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("t6 i%0d mem_wstrb", m), seen[m][7], 32'h0);
            chk($sformatf("t6 i%0d mem_we", m), seen[m][3], 32'h0);
            chk($sformatf("t6 i%0d mem_re", m), seen[m][2], 32'h1);
        end
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step("t2 resp");
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("t2 i%0d p0_rvalid", m), seen[m][8], 32'h1);
            chk($sformatf("t2 i%0d p0_rdata", m), seen[m][10], 32'hDEADBEEF);
        end

        // Reset lands while a read response is due.
        drive(0, 1, 0, 32'h10, 32'h0, 4'h0, 0);
        step("t1 read");
        for (int m = 0; m < 2; m++) chk($sformatf("t1 i%0d rvalid before rst", m), obs(m, 8), 32'h1);
        drive(1, 1, 0, 32'h14, 32'h0, 4'h0, 0);
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("t1 i%0d p0_rvalid in rst", m), obs(m, 8), 32'h0);
            chk($sformatf("t1 i%0d p0_ready in rst", m), obs(m, 0), 32'h0);
            chk($sformatf("t1 i%0d p1_ready in rst", m), obs(m, 1), 32'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step("t1 after rst");

        // Both read continuously: RR alternates from P0, fixed grants P1 on the 4th cycle.
        drive(0, 1, 0, 32'h10, 32'h0, 4'h0, 0);
        drive(1, 1, 0, 32'h14, 32'h0, 4'h0, 0);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("t34 c%0d", i));
            chk($sformatf("t3 c%0d rr p0_ready", i), seen[0][0], 32'(i % 2 == 0));
            chk($sformatf("t3 c%0d rr p1_ready", i), seen[0][1], 32'(i % 2 == 1));
            chk($sformatf("t4 c%0d fx p1_ready", i), seen[1][1], 32'(i == 3));
        end
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step("t34 drain");

        // P1 locked burst; P0 must stall, including while P1 briefly drops valid.
        drive(1, 1, 0, 32'h20, 32'h0, 4'h0, 1);
        step("t5 beat0");
        for (int m = 0; m < 2; m++) chk($sformatf("t5 i%0d beat0 p1_ready", m), seen[m][1], 32'h1);
        drive(0, 1, 0, 32'h18, 32'h0, 4'h0, 0);
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step("t5 gap");
        for (int m = 0; m < 2; m++) chk($sformatf("t5 i%0d gap p0_ready", m), seen[m][0], 32'h0);
        drive(1, 1, 0, 32'h24, 32'h0, 4'h0, 1);
        step("t5 beat1");
        for (int m = 0; m < 2; m++) chk($sformatf("t5 i%0d beat1 p0_ready", m), seen[m][0], 32'h0);
        drive(1, 1, 0, 32'h28, 32'h0, 4'h0, 0);
        step("t5 beat2");
        for (int m = 0; m < 2; m++) chk($sformatf("t5 i%0d beat2 p0_ready", m), seen[m][0], 32'h0);
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step("t5 release");
        for (int m = 0; m < 2; m++) chk($sformatf("t5 i%0d release p0_ready", m), seen[m][0], 32'h1);
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step("t5 drain");

        // Random traffic; a request is held until the round-robin instance takes it.
        for (int i = 0; i < 400; i++) begin
            if (!p0_valid || last_g[0] == 0)
                drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom), $urandom_range(0, 4) == 0);
            if (!p1_valid || last_g[0] == 1)
                drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom), $urandom_range(0, 4) == 0);
            step("rnd");
        end
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
        step("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
